// File: rtl/sys_defs.sv
// sys_defs: shared widths, FSM states and requester ids for the arbiter.
// Build macro MEM_ARB_WRITE_PRIORITY_EN lets compressor writes beat reads.
`ifndef MEM_BANDWIDTH
`define MEM_BANDWIDTH 4
`endif
`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 16
`endif

package sys_defs;

  localparam int MEM_DATA_W = `MEM_BANDWIDTH * 8;
  localparam int MEM_ADDR_W = `MEM_ADDR_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    WRITE
  } mem_arb_state;

  typedef enum logic [1:0] {
    DEC,
    WGT,
    COMP
  } mem_req_id;

  function automatic mem_req_id onehot_to_id(
    input logic [2:0] oh
  );
    mem_req_id id;
    id = DEC;
    unique case (1'b1)
      oh[1]:   id = WGT;
      oh[2]:   id = COMP;
      default: id = DEC;
    endcase
    return id;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// rr_arbiter3: three-way round-robin picker, one-hot grant.
// Search starts just after the last accepted winner (dec, wgt, comp).
module rr_arbiter3
  import sys_defs::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       accept,
  output logic [2:0] gnt
);

  mem_req_id last;

  // first active requester after the previous winner
  always_comb begin
    gnt = 3'b000;
    unique case (last)
      DEC: begin
        if (req[1])      gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      WGT: begin
        if (req[2])      gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      default: begin
        if (req[0])      gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
    endcase
  end

  // remember the winner once its grant is taken
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= COMP;
    end else if (accept) begin
      last <= onehot_to_id(gnt);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port among dec/wgt reads and comp writes.
// Optional MEM_ARB_WRITE_PRIORITY_EN: comp_req always wins in IDLE.
module mem_port_arbiter
  import sys_defs::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int ADDR_STEP   = `MEM_BANDWIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [MEM_ADDR_W-1:0] ifmap_start_addr,
  input  logic [MEM_ADDR_W-1:0] weight_start_addr,
  input  logic [MEM_ADDR_W-1:0] comp_start_addr,
  input  logic                  dec_req,
  input  logic                  wgt_req,
  input  logic                  comp_req,
  input  logic [MEM_DATA_W-1:0] comp_data,
  input  logic [MEM_DATA_W-1:0] mem_read_data,
  input  logic                  mem_valid,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [MEM_DATA_W-1:0] mem_write_data,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  dec_ack,
  output logic                  wgt_ack,
  output logic                  comp_ack,
  output logic [MEM_DATA_W-1:0] rd_data,
  output logic                  busy,
  output logic                  error
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1) + 1;

  typedef logic [MEM_ADDR_W-1:0] addr_t;

  mem_arb_state                 state;
  mem_arb_state                 state_nxt;
  mem_req_id                    gnt_id;
  mem_req_id                    sel_id;
  logic [2:0][MEM_ADDR_W-1:0]   cnt;
  logic [TW-1:0]                wait_cnt;
  logic                         stale;
  logic                         idle;
  logic                         take;
  logic                         timeout;
  logic                         rd_done;
  logic                         bump;
  logic [2:0]                   arb_req;
  logic [2:0]                   arb_gnt;
  logic [2:0]                   sel;
  logic                         arb_accept;

  assign idle = (state == IDLE);

`ifdef MEM_ARB_WRITE_PRIORITY_EN
  assign arb_req    = {1'b0, wgt_req, dec_req};
  assign sel        = comp_req ? 3'b100 : arb_gnt;
  assign arb_accept = idle && !comp_req && (arb_gnt != 3'b000);
`else
  assign arb_req    = {comp_req, wgt_req, dec_req};
  assign sel        = arb_gnt;
  assign arb_accept = idle && (arb_gnt != 3'b000);
`endif

  rr_arbiter3 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (arb_req),
    .accept (arb_accept),
    .gnt    (arb_gnt)
  );

  assign take    = idle && (sel != 3'b000);
  assign sel_id  = onehot_to_id(sel);
  assign rd_done = (state == READ_WAIT) && mem_valid;
  assign timeout = (state == READ_WAIT) && !mem_valid
                && (wait_cnt == TW'(TIMEOUT_CYC));
  assign bump    = (rd_done && !stale) || (state == WRITE);

  // transaction phase sequencing
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (take) begin
          state_nxt = (sel_id == COMP) ? WRITE : READ_WAIT;
        end
      end
      READ_WAIT: begin
        if (rd_done || timeout) state_nxt = IDLE;
      end
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // port outputs, beat pulses, address counters and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      gnt_id         <= DEC;
      cnt            <= '0;
      wait_cnt       <= '0;
      stale          <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      dec_ack        <= 1'b0;
      wgt_ack        <= 1'b0;
      comp_ack       <= 1'b0;
      rd_data        <= '0;
      busy           <= 1'b0;
      error          <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != IDLE);
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      dec_ack   <= 1'b0;
      wgt_ack   <= 1'b0;
      comp_ack  <= 1'b0;
      if (take) begin
        gnt_id   <= sel_id;
        mem_addr <= cnt[sel_id];
        wait_cnt <= '0;
        stale    <= 1'b0;
        if (sel_id == COMP) begin
          mem_write      <= 1'b1;
          mem_write_data <= comp_data;
          comp_ack       <= 1'b1;
        end else begin
          mem_read <= 1'b1;
        end
      end
      if (rd_done && !stale) begin
        rd_data <= mem_read_data;
        dec_ack <= (gnt_id == DEC);
        wgt_ack <= (gnt_id == WGT);
      end
      if ((state == READ_WAIT) && !mem_valid) begin
        wait_cnt <= wait_cnt + TW'(1);
      end
      if (start) begin
        cnt[DEC]  <= ifmap_start_addr;
        cnt[WGT]  <= weight_start_addr;
        cnt[COMP] <= comp_start_addr;
        stale     <= (state == READ_WAIT);
        error     <= 1'b0;
      end else begin
        if (bump) begin
          cnt[gnt_id] <= cnt[gnt_id] + addr_t'(ADDR_STEP);
        end
        if (timeout) error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized transaction bench with a reference model.
// Build with +define+MEM_ARB_WRITE_PRIORITY_EN to check write priority.
module tb_mem_port_arbiter;
  import sys_defs::*;

  localparam int STEP = `MEM_BANDWIDTH;
  localparam int SPAN = 1 << MEM_ADDR_W;
  localparam int TMO  = 255;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [MEM_ADDR_W-1:0] ifmap_start_addr;
  logic [MEM_ADDR_W-1:0] weight_start_addr;
  logic [MEM_ADDR_W-1:0] comp_start_addr;
  logic                  dec_req;
  logic                  wgt_req;
  logic                  comp_req;
  logic [MEM_DATA_W-1:0] comp_data;
  logic [MEM_DATA_W-1:0] mem_read_data;
  logic                  mem_valid;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [MEM_DATA_W-1:0] mem_write_data;
  logic                  mem_read;
  logic                  mem_write;
  logic                  dec_ack;
  logic                  wgt_ack;
  logic                  comp_ack;
  logic [MEM_DATA_W-1:0] rd_data;
  logic                  busy;
  logic                  error;

  int vectors     = 0;
  int miscompares = 0;
  int exp_cnt [3];
  int rr_last;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .TIMEOUT_CYC (TMO),
    .ADDR_STEP   (STEP)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .ifmap_start_addr  (ifmap_start_addr),
    .weight_start_addr (weight_start_addr),
    .comp_start_addr   (comp_start_addr),
    .dec_req           (dec_req),
    .wgt_req           (wgt_req),
    .comp_req          (comp_req),
    .comp_data         (comp_data),
    .mem_read_data     (mem_read_data),
    .mem_valid         (mem_valid),
    .mem_addr          (mem_addr),
    .mem_write_data    (mem_write_data),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .dec_ack           (dec_ack),
    .wgt_ack           (wgt_ack),
    .comp_ack          (comp_ack),
    .rd_data           (rd_data),
    .busy              (busy),
    .error             (error)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int predict(input logic [2:0] m);
    logic [2:0] mm;
    int c;
    mm = m;
`ifdef MEM_ARB_WRITE_PRIORITY_EN
    if (m[2]) return 2;
    mm[2] = 1'b0;
`endif
    for (int k = 1; k <= 3; k++) begin
      c = (rr_last + k) % 3;
      if (mm[c]) return c;
    end
    return -1;
  endfunction

  task automatic note_grant(input int who);
`ifdef MEM_ARB_WRITE_PRIORITY_EN
    if (who != 2) rr_last = who;
`else
    rr_last = who;
`endif
  endtask

  task automatic set_req(input logic [2:0] m);
    dec_req  = m[0];
    wgt_req  = m[1];
    comp_req = m[2];
  endtask

  task automatic do_start(input int a, input int b, input int c);
    ifmap_start_addr  = MEM_ADDR_W'(a);
    weight_start_addr = MEM_ADDR_W'(b);
    comp_start_addr   = MEM_ADDR_W'(c);
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_cnt[0] = a;
    exp_cnt[1] = b;
    exp_cnt[2] = c;
  endtask

  task automatic grab(input logic [2:0] m, output int who);
    int n;
    int p;
    p = predict(m);
    who = -1;
    comp_data = MEM_DATA_W'($urandom());
    set_req(m);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(mem_read || mem_write) && n < 40);
    if (!(mem_read || mem_write)) begin
      chk("grant_seen", 64'd0, 64'd1);
      return;
    end
    who = p;
    chk("grant_kind", mem_write, p == 2);
    chk("grant_addr", mem_addr, exp_cnt[p]);
    note_grant(p);
    if (p == 2) begin
      chk("wr_data", mem_write_data, comp_data);
      chk("wr_ack", comp_ack, 1'b1);
      exp_cnt[2] = (exp_cnt[2] + STEP) % SPAN;
    end
  endtask

  task automatic finish_read(input int who, input int lat, input bit drop);
    logic [MEM_DATA_W-1:0] d;
    if (drop) set_req(3'b000);
    for (int i = 0; i < lat; i++) begin
      tick();
      if (i == 0) chk("rd_pulse", mem_read, 1'b0);
    end
    d = MEM_DATA_W'($urandom());
    mem_read_data = d;
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    mem_read_data = MEM_DATA_W'($urandom());
    chk("rd_ack", {comp_ack, wgt_ack, dec_ack}, 3'b001 << who);
    chk("rd_data", rd_data, d);
    chk("rd_idle", busy, 1'b0);
    exp_cnt[who] = (exp_cnt[who] + STEP) % SPAN;
  endtask

  task automatic serve(input logic [2:0] m, input int lat, input bit drop);
    int who;
    grab(m, who);
    if (who == 2) begin
      set_req(3'b000);
      tick();
      chk("wr_pulse", {mem_write, comp_ack}, 2'b00);
    end else if (who >= 0) begin
      finish_read(who, lat, drop);
    end
    set_req(3'b000);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int who;
    int n;
    bit saw_ack;
    rst = 1'b1;
    start = 1'b0;
    ifmap_start_addr = '0;
    weight_start_addr = '0;
    comp_start_addr = '0;
    set_req(3'b000);
    comp_data = '0;
    mem_read_data = '0;
    mem_valid = 1'b0;
    rr_last = 2;
    for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_strobes", {mem_read, mem_write}, 2'b00);
    chk("rst_acks", {comp_ack, wgt_ack, dec_ack}, 3'b000);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rdata", rd_data, 0);
    rst = 1'b0;
    tick();

    do_start(32'h100, 32'h200, 32'h300);
    repeat (4) serve(3'b001, 3, 1'b0);

    repeat (60) begin
      serve(3'($urandom_range(1, 7)), $urandom_range(0, 6),
            1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        chk("stray_acks", {comp_ack, wgt_ack, dec_ack}, 3'b000);
        chk("stray_busy", busy, 1'b0);
      end
    end

    grab(3'b001, who);
    set_req(3'b000);
    n = 0;
    saw_ack = 1'b0;
    while (busy && n < 400) begin
      tick();
      n++;
      if (dec_ack || wgt_ack || comp_ack) saw_ack = 1'b1;
    end
    chk("to_idle", busy, 1'b0);
    chk("to_len", n, TMO + 1);
    chk("to_error", error, 1'b1);
    chk("to_noack", saw_ack, 1'b0);
    serve(3'b001, 2, 1'b0);
    chk("to_sticky", error, 1'b1);
    do_start(32'h100, 32'h200, 32'h300);
    chk("to_clear", error, 1'b0);

    grab(3'b010, who);
    set_req(3'b000);
    repeat (TMO) tick();
    chk("co_busy", busy, 1'b1);
    do_start(32'h140, 32'h240, 32'h340);
    chk("co_error", error, 1'b0);
    chk("co_idle", busy, 1'b0);

    grab(3'b001, who);
    set_req(3'b000);
    tick();
    do_start(32'h800, 32'h200, 32'h300);
    tick();
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    chk("stale_acks", {comp_ack, wgt_ack, dec_ack}, 3'b000);
    chk("stale_idle", busy, 1'b0);
    serve(3'b001, 1, 1'b0);

    do_start(32'h100, 32'h200, SPAN - STEP);
    serve(3'b100, 0, 1'b0);
    serve(3'b100, 0, 1'b0);

    grab(3'b001, who);
    set_req(3'b000);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_valid = 1'b1;
    mem_read_data = MEM_DATA_W'($urandom());
    tick();
    mem_valid = 1'b0;
    chk("late_acks", {comp_ack, wgt_ack, dec_ack}, 3'b000);
    chk("late_busy", busy, 1'b0);
    rr_last = 2;
    for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
    repeat (6) serve(3'b111, $urandom_range(0, 4), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
